// File: rtl/bram_cycle_ctrl_if.sv
// Bundle of BRAM strobes/buses, core memory requests and host (loader/debug)
// requests seen by the BRAM cycle controller.
interface bram_cycle_ctrl_if #(
    parameter int WORD_SIZE = 16,
    parameter int DADDR_W   = 3
);
    logic                 run;

    logic                 i1re;
    logic                 i2re;
    logic                 dre;
    logic                 gwe;
    logic                 dwe;
    logic [DADDR_W-1:0]   draddr;
    logic [DADDR_W-1:0]   dwaddr;
    logic [WORD_SIZE-1:0] din;
    logic [WORD_SIZE-1:0] dout;

    logic [DADDR_W-1:0]   core_draddr;
    logic [DADDR_W-1:0]   core_dwaddr;
    logic [WORD_SIZE-1:0] core_din;
    logic                 core_dwe;
    logic                 core_adv;

    logic                 host_req;
    logic                 host_we;
    logic [DADDR_W-1:0]   host_addr;
    logic [WORD_SIZE-1:0] host_wdata;
    logic                 host_ack;
    logic [WORD_SIZE-1:0] host_rdata;

    modport master (
        input  run, dout,
        input  core_draddr, core_dwaddr, core_din, core_dwe,
        input  host_req, host_we, host_addr, host_wdata,
        output i1re, i2re, dre, gwe, dwe, draddr, dwaddr, din,
        output core_adv, host_ack, host_rdata
    );

    modport slave (
        output run, dout,
        output core_draddr, core_dwaddr, core_din, core_dwe,
        output host_req, host_we, host_addr, host_wdata,
        input  i1re, i2re, dre, gwe, dwe, draddr, dwaddr, din,
        input  core_adv, host_ack, host_rdata
    );
endinterface

// File: rtl/bram_cycle_ctrl.sv
// Phase sequencer for the instruction/data BRAM: one strobe per idclk and
// whole-frame arbitration of the data port between the core and a host.
module bram_cycle_ctrl #(
    parameter int WORD_SIZE = 16,
    parameter int DADDR_W   = 3
) (
    input  logic               idclk,
    input  logic               rst,
    bram_cycle_ctrl_if.master  bus
);

    typedef enum logic [3:0] {
        IDLE,
        C_I1, C_I2, C_D, C_G,
        H_I1, H_I2, H_D, H_CAP,
        H_W
    } state_t;

    state_t               state;
    state_t               nxt;
    logic                 last_host;

    logic                 i1re_q;
    logic                 i2re_q;
    logic                 dre_q;
    logic                 gwe_q;
    logic                 core_adv_q;
    logic                 host_ack_q;
    logic [WORD_SIZE-1:0] host_rdata_q;

    logic [DADDR_W-1:0]   draddr_mux;
    logic [DADDR_W-1:0]   dwaddr_mux;
    logic [WORD_SIZE-1:0] din_mux;
    logic                 dwe_mux;

    // Frame-boundary arbitration; the host only wins over a pending core
    // frame if the previous frame was a core frame (alternation).
    function automatic state_t boundary(
        input logic pend,
        input logic we,
        input logic prev_host,
        input logic run_en
    );
        if (pend && (!prev_host || !run_en))
            return we ? H_W : H_I1;
        else if (run_en)
            return C_I1;
        else
            return IDLE;
    endfunction

    // The request being completed in H_CAP/H_W is not re-arbitrated there;
    // a req still high in the following ack cycle is seen as a new request.
    always_comb begin
        nxt = IDLE;
        unique case (state)
            IDLE:    nxt = boundary(bus.host_req, bus.host_we, last_host, bus.run);
            C_I1:    nxt = C_I2;
            C_I2:    nxt = C_D;
            C_D:     nxt = C_G;
            C_G:     nxt = boundary(bus.host_req, bus.host_we, last_host, bus.run);
            H_I1:    nxt = H_I2;
            H_I2:    nxt = H_D;
            H_D:     nxt = H_CAP;
            H_CAP:   nxt = boundary(1'b0, 1'b0, last_host, bus.run);
            H_W:     nxt = boundary(1'b0, 1'b0, last_host, bus.run);
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge idclk) begin
        if (rst) begin
            state        <= IDLE;
            last_host    <= 1'b0;
            i1re_q       <= 1'b0;
            i2re_q       <= 1'b0;
            dre_q        <= 1'b0;
            gwe_q        <= 1'b0;
            core_adv_q   <= 1'b0;
            host_ack_q   <= 1'b0;
            host_rdata_q <= '0;
        end else begin
            state      <= nxt;
            i1re_q     <= (nxt == C_I1) || (nxt == H_I1);
            i2re_q     <= (nxt == C_I2) || (nxt == H_I2);
            dre_q      <= (nxt == C_D)  || (nxt == H_D);
            gwe_q      <= (nxt == C_G)  || (nxt == H_W);
            core_adv_q <= (nxt == C_G);
            host_ack_q <= (state == H_CAP) || (state == H_W);
            if (state == H_CAP)
                host_rdata_q <= bus.dout;
            if (nxt == C_I1)
                last_host <= 1'b0;
            else if ((nxt == H_I1) || (nxt == H_W))
                last_host <= 1'b1;
        end
    end

    // Data-port muxing follows the registered state, never the inputs' timing.
    always_comb begin
        draddr_mux = (state == H_D) ? bus.host_addr : bus.core_draddr;
        dwaddr_mux = (state == H_W) ? bus.host_addr : bus.core_dwaddr;
        din_mux    = (state == H_W) ? bus.host_wdata : bus.core_din;
        dwe_mux    = (state == H_W) || ((state == C_G) && bus.core_dwe);
    end

    assign bus.i1re       = i1re_q;
    assign bus.i2re       = i2re_q;
    assign bus.dre        = dre_q;
    assign bus.gwe        = gwe_q;
    assign bus.dwe        = dwe_mux;
    assign bus.draddr     = draddr_mux;
    assign bus.dwaddr     = dwaddr_mux;
    assign bus.din        = din_mux;
    assign bus.core_adv   = core_adv_q;
    assign bus.host_ack   = host_ack_q;
    assign bus.host_rdata = host_rdata_q;

endmodule

// File: tb/tb_bram_cycle_ctrl.sv
// Directed bench for bram_cycle_ctrl with a small synchronous BRAM model.
module tb_bram_cycle_ctrl;
    localparam int WS = 16;
    localparam int AW = 3;

    logic idclk = 1'b0;
    logic rst   = 1'b1;
    always #5 idclk = ~idclk;

    bram_cycle_ctrl_if #(.WORD_SIZE(WS), .DADDR_W(AW)) bus ();

    bram_cycle_ctrl #(.WORD_SIZE(WS), .DADDR_W(AW)) dut (
        .idclk (idclk),
        .rst   (rst),
        .bus   (bus)
    );

    // BRAM model: read data valid the cycle after dre, write on dwe.
    logic [WS-1:0] mem [8];
    always @(posedge idclk) begin
        if (bus.dre) bus.dout <= mem[bus.draddr];
        if (bus.dwe) mem[bus.dwaddr] <= bus.din;
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge idclk);
        #1;
    endtask

    function automatic logic [3:0] strb();
        return {bus.i1re, bus.i2re, bus.dre, bus.gwe};
    endfunction

    initial begin
        logic [3:0] e;
        int last_adv, max_gap, nadv, nack, rd_bad;

        bus.run = 1'b0;
        bus.core_draddr = '0; bus.core_dwaddr = '0; bus.core_din = '0; bus.core_dwe = 1'b0;
        bus.host_req = 1'b0; bus.host_we = 1'b0; bus.host_addr = '0; bus.host_wdata = '0;

        // 1: reset then free-running core frames
        tick(); tick();
        chk("rst_strb", strb(), 4'b0000);
        chk("rst_adv", bus.core_adv, 1'b0);
        chk("rst_ack", bus.host_ack, 1'b0);
        chk("rst_rdata", bus.host_rdata, 16'h0);
        chk("rst_dwe", bus.dwe, 1'b0);
        rst = 1'b0;
        bus.run = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            e = 4'b1000 >> (i % 4);
            chk("core_strb", strb(), e);
            chk("core_adv", bus.core_adv, (i % 4) == 3);
        end

        // 2: host write arrives mid core frame
        tick();
        chk("t2_i1", strb(), 4'b1000);
        bus.host_req = 1'b1; bus.host_we = 1'b1; bus.host_addr = 3'd3; bus.host_wdata = 16'hBEEF;
        bus.core_dwe = 1'b1; bus.core_dwaddr = 3'd5; bus.core_din = 16'h1234; bus.core_draddr = 3'd6;
        tick();
        chk("t2_i2", strb(), 4'b0100);
        chk("t2_i2_dwe", bus.dwe, 1'b0);
        tick();
        chk("t2_d", strb(), 4'b0010);
        chk("t2_core_draddr", bus.draddr, 3'd6);
        tick();
        chk("t2_cg", strb(), 4'b0001);
        chk("t2_cg_adv", bus.core_adv, 1'b1);
        chk("t2_cg_dwe", bus.dwe, 1'b1);
        chk("t2_cg_dwaddr", bus.dwaddr, 3'd5);
        chk("t2_cg_din", bus.din, 16'h1234);
        tick();
        chk("t2_hw", strb(), 4'b0001);
        chk("t2_hw_dwe", bus.dwe, 1'b1);
        chk("t2_hw_dwaddr", bus.dwaddr, 3'd3);
        chk("t2_hw_din", bus.din, 16'hBEEF);
        chk("t2_hw_adv", bus.core_adv, 1'b0);
        chk("t2_hw_ack", bus.host_ack, 1'b0);
        tick();
        chk("t2_ack", bus.host_ack, 1'b1);
        chk("t2_resume", strb(), 4'b1000);
        bus.host_req = 1'b0; bus.core_dwe = 1'b0;

        // 3: host read of the word just written
        bus.host_req = 1'b1; bus.host_we = 1'b0; bus.host_addr = 3'd3;
        tick(); tick(); tick();
        chk("t3_cg_adv", bus.core_adv, 1'b1);
        chk("t3_cg_dwe", bus.dwe, 1'b0);
        tick();
        chk("t3_hi1", strb(), 4'b1000);
        chk("t3_hi1_adv", bus.core_adv, 1'b0);
        tick();
        chk("t3_hi2", strb(), 4'b0100);
        chk("t3_hi2_adv", bus.core_adv, 1'b0);
        tick();
        chk("t3_hd", strb(), 4'b0010);
        chk("t3_hd_draddr", bus.draddr, 3'd3);
        chk("t3_hd_adv", bus.core_adv, 1'b0);
        tick();
        chk("t3_hcap", strb(), 4'b0000);
        chk("t3_hcap_adv", bus.core_adv, 1'b0);
        chk("t3_hcap_ack", bus.host_ack, 1'b0);
        tick();
        chk("t3_ack", bus.host_ack, 1'b1);
        chk("t3_rdata", bus.host_rdata, 16'hBEEF);
        chk("t3_resume", strb(), 4'b1000);
        bus.host_req = 1'b0;
        tick();
        chk("t3_ack_pulse", bus.host_ack, 1'b0);
        chk("t3_rdata_hold", bus.host_rdata, 16'hBEEF);

        // 4: host_req held continuously, frames alternate
        bus.host_req = 1'b1; bus.host_we = 1'b0; bus.host_addr = 3'd5;
        last_adv = -1; max_gap = 0; nadv = 0; nack = 0; rd_bad = 0;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (bus.core_adv) begin
                if (last_adv >= 0 && (c - last_adv) > max_gap) max_gap = c - last_adv;
                last_adv = c;
                nadv++;
            end
            if (bus.host_ack) begin
                nack++;
                if (bus.host_rdata !== 16'h1234) rd_bad++;
            end
        end
        chk("t4_nadv", nadv, 5);
        chk("t4_nack", nack, 5);
        chk("t4_gap", max_gap, 8);
        chk("t4_rdata", rd_bad, 0);
        bus.host_req = 1'b0; bus.run = 1'b0;

        // 5: idle with run=0, host served directly from IDLE
        for (int i = 0; i < 6; i++) tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t5_idle_strb", strb(), 4'b0000);
            chk("t5_idle_adv", bus.core_adv, 1'b0);
        end
        bus.host_req = 1'b1; bus.host_we = 1'b0; bus.host_addr = 3'd5;
        tick();
        chk("t5_hi1", strb(), 4'b1000);
        tick(); tick();
        chk("t5_hd", strb(), 4'b0010);
        chk("t5_hd_draddr", bus.draddr, 3'd5);
        tick(); tick();
        chk("t5_ack", bus.host_ack, 1'b1);
        chk("t5_rdata", bus.host_rdata, 16'h1234);
        chk("t5_ack_strb", strb(), 4'b0000);
        bus.host_req = 1'b0;
        tick();
        chk("t5_ack_pulse", bus.host_ack, 1'b0);
        chk("t5_stay_idle", strb(), 4'b0000);
        bus.host_req = 1'b1; bus.host_we = 1'b1; bus.host_addr = 3'd2; bus.host_wdata = 16'hA5A5;
        tick();
        chk("t5_hw_dwe", bus.dwe, 1'b1);
        chk("t5_hw_dwaddr", bus.dwaddr, 3'd2);
        chk("t5_hw_din", bus.din, 16'hA5A5);
        tick();
        chk("t5_hw_ack", bus.host_ack, 1'b1);
        chk("t5_hw_idle", strb(), 4'b0000);
        bus.host_req = 1'b0; bus.host_we = 1'b0;
        tick();

        // 6: reset during H_D aborts without ack, request re-served after
        bus.host_req = 1'b1; bus.host_addr = 3'd3;
        tick(); tick(); tick();
        chk("t6_hd", strb(), 4'b0010);
        rst = 1'b1;
        tick();
        chk("t6_rst_strb", strb(), 4'b0000);
        chk("t6_rst_ack", bus.host_ack, 1'b0);
        chk("t6_rst_rdata", bus.host_rdata, 16'h0);
        rst = 1'b0;
        tick();
        chk("t6_hi1", strb(), 4'b1000);
        chk("t6_no_ack", bus.host_ack, 1'b0);
        tick(); tick(); tick();
        chk("t6_hcap_ack", bus.host_ack, 1'b0);
        tick();
        chk("t6_ack", bus.host_ack, 1'b1);
        chk("t6_rdata", bus.host_rdata, 16'hBEEF);
        bus.host_req = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
